regfile_scb: RTL and testbench
==============================

# regfile_scb

Parametrised integer register file with a built-in register-status scoreboard for the out-of-order RISC-V core. It sits between issue/dispatch and the commit stage. It provides NREAD combinational read ports with same-cycle write bypass. Each register carries a busy bit and a producer tag: dispatch allocates, commit releases on tag match, and a flush clears all pending producers.

## Interface
- XLEN, 32, register data width
- NREG, 32, number of architectural registers (power of two, ≥ 2)
- NREAD, 2, number of read ports (1–4)
- TAGW, 4, producer-tag width (ROB index)
- AW, log2(NREG), register address width (derived, not overridable)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low; clears all registers, busy bits, tags, counter
- we  in  1  commit write enable
- waddr  in  AW  commit destination register
- wdata  in  XLEN  commit data
- wtag  in  TAGW  tag of committing instruction
- alloc  in  1  dispatch allocate enable
- alloc_addr  in  AW  register being renamed
- alloc_tag  in  TAGW  tag of new producer
- flush  in  1  clear all busy bits (mispredict/exception)
- re  in  NREAD  per-port read enable
- raddr  in  NREAD*AW  packed read addresses, port i at [i*AW +: AW]
- rdata  out  NREAD*XLEN  packed read data
- rbusy  out  NREAD  register has an outstanding producer
- rtag  out  NREAD*TAGW  producer tag (valid when rbusy=1)
- busy_cnt  out  AW+1  number of registers currently busy

## Operation
- Register 0 is hard zero: never written, never busy; alloc/commit addressed to 0 are ignored.
- Commit (we=1, waddr≠0): regs[waddr] ← wdata unconditionally. busy[waddr] is cleared only if busy[waddr]=1, tag[waddr]=wtag, and there is no same-cycle alloc to waddr.
- Alloc (alloc=1, alloc_addr≠0, flush=0): busy ← 1, tag ← alloc_tag. Overrides a same-cycle commit release to the same register.
- Flush: all busy bits ← 0 next edge. Flush beats a same-cycle alloc, which is dropped. A same-cycle commit still writes data.
- Read port i, priority order:
  - rst low → zeros.
  - re[i]=0 → rdata=0, rbusy=0, rtag=0.
  - raddr=0 → rdata=0, rbusy=0.
  - we and raddr=waddr → rdata=wdata (bypass). rbusy=0 if the commit releases that register this cycle, else the stored busy.
  - Otherwise → regs/busy/tag.
- Reads never observe a same-cycle alloc. Dispatch handles intra-group dependencies.
- busy_cnt is a registered count of set busy bits. It is updated incrementally by +1/−1/0 per cycle and set to 0 on flush; it must equal popcount(busy) every cycle.

## Timing
- Reads: combinational, zero latency.
- Commit/alloc/flush effects: stored values are visible to non-bypassed reads from the cycle after the edge.
- Reset asserted mid-operation: all state clears immediately (asynchronous). Outputs read zero while rst=0. First valid write is on the first rising edge with rst=1.
- Re-alloc of a busy register overwrites the tag; the older producer's commit no longer releases it.
- busy_cnt saturates structurally at NREG−1 (x0 is never busy), so there is no overflow.

## Structure
- Shared package regfile_pkg holds:
  - constants: XLEN default, REG_AW, TAG_W, ZERO_WORD
  - enable/disable level constants (WRITE_EN, READ_EN, RST_ACTIVE=1'b0)
  - function clog2
- Sub-module regfile_rdport: one read port containing the bypass/priority mux. It is instantiated NREAD times via generate.
- The top level holds the storage arrays, the scoreboard update logic, and the counter.

## Test plan
- Reset then read: rst low, raddr=5 on all ports → rdata=0, rbusy=0, busy_cnt=0. Release rst, commit x5=0xDEADBEEF → next cycle read x5=0xDEADBEEF.
- Bypass: we=1, waddr=7, wdata=0x1234, raddr0=7 same cycle → rdata0=0x1234; raddr1=8 → old x8.
- Tag match:
  - alloc x3 tag 2, then commit x3 tag 1 → data written, rbusy=1, rtag=2, busy_cnt=1.
  - commit x3 tag 2 → rbusy=0 same cycle, busy_cnt=0 next cycle.
- Simultaneous: alloc x4 tag 5 and commit x4 tag 3 (busy, tag 3) same edge → x4 busy, tag 5, data=commit data, busy_cnt unchanged.
- Flush: alloc x1,x2,x9, then flush together with alloc x10 → all busy=0, x10 not busy, busy_cnt=0.
- x0 and port disable: alloc/commit to x0 → rdata=0, rbusy=0, busy_cnt unchanged. re[1]=0 → port 1 outputs all zero. Async rst pulse mid-traffic clears busy_cnt without a clock edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the integer register file and its
// register-status scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REG_AW   = 5;
  localparam int TAG_W    = 4;

  localparam logic [XLEN_DEF-1:0] ZERO_WORD = '0;

  localparam logic WRITE_EN   = 1'b1;
  localparam logic READ_EN    = 1'b1;
  localparam logic RST_ACTIVE = 1'b0;

  // Ceiling log2. Used to derive the register address width from NREG.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port. It applies the priority order:
// reset, port disable, x0, same-cycle commit bypass, then stored state.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = REG_AW,
  parameter int TAGW = TAG_W
) (
  input  logic            i_rst_n,
  input  logic            i_re,
  input  logic [AW-1:0]   i_raddr,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic            i_release,
  input  logic [XLEN-1:0] i_st_data,
  input  logic            i_st_busy,
  input  logic [TAGW-1:0] i_st_tag,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_rbusy,
  output logic [TAGW-1:0] o_rtag
);

  logic w_active;
  logic w_bypass;

  assign w_active = (i_rst_n != RST_ACTIVE) && (i_re == READ_EN) && (i_raddr != '0);
  assign w_bypass = (i_we == WRITE_EN) && (i_raddr == i_waddr);

  always_comb begin
    o_rdata = '0;
    o_rbusy = 1'b0;
    o_rtag  = '0;
    if (w_active) begin
      o_rtag = i_st_tag;
      if (w_bypass) begin
        // A matching commit that releases this register clears busy in the same cycle.
        o_rdata = i_wdata;
        o_rbusy = i_release ? 1'b0 : i_st_busy;
      end else begin
        o_rdata = i_st_data;
        o_rbusy = i_st_busy;
      end
    end
  end

endmodule

// File: rtl/regfile_scb.sv
// Integer register file with per-register busy bit and producer tag.
// Dispatch allocates, commit writes data and releases on tag match, flush clears busy.
module regfile_scb
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREG  = 32,
  parameter int NREAD = 2,
  parameter int TAGW  = TAG_W,
  localparam int AW   = clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [TAGW-1:0]       wtag,
  input  logic                  alloc,
  input  logic [AW-1:0]         alloc_addr,
  input  logic [TAGW-1:0]       alloc_tag,
  input  logic                  flush,
  input  logic [NREAD-1:0]      re,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*XLEN-1:0] rdata,
  output logic [NREAD-1:0]      rbusy,
  output logic [NREAD*TAGW-1:0] rtag,
  output logic [AW:0]           busy_cnt
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [TAGW-1:0] r_tag  [NREG];
  logic [NREG-1:0] r_busy;
  logic [AW:0]     r_busy_cnt;

  logic            w_commit;
  logic            w_alloc;
  logic            w_release;
  logic            w_alloc_new;
  logic [NREG-1:0] w_busy_nxt;

  assign w_commit = (we == WRITE_EN) && (waddr != '0);
  // Flush drops a same-cycle allocation entirely.
  assign w_alloc  = alloc && (alloc_addr != '0) && !flush;

  // Release needs a live producer with matching tag and no re-rename this cycle.
  assign w_release   = w_commit && r_busy[waddr] && (r_tag[waddr] == wtag) &&
                       !(w_alloc && (alloc_addr == waddr));
  assign w_alloc_new = w_alloc && !r_busy[alloc_addr];

  always_comb begin
    w_busy_nxt = r_busy;
    if (flush) begin
      w_busy_nxt = '0;
    end else begin
      if (w_release) w_busy_nxt[waddr] = 1'b0;
      if (w_alloc)   w_busy_nxt[alloc_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
        r_tag[i]  <= '0;
      end
    end else begin
      if (w_commit) r_regs[waddr] <= wdata;
      if (w_alloc)  r_tag[alloc_addr] <= alloc_tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Incremental popcount: a new allocation adds one, a release removes one.
  // They never target the same register, because alloc suppresses the release.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      r_busy_cnt <= '0;
    end else if (flush) begin
      r_busy_cnt <= '0;
    end else begin
      case ({w_alloc_new, w_release})
        2'b10:   r_busy_cnt <= r_busy_cnt + 1'b1;
        2'b01:   r_busy_cnt <= r_busy_cnt - 1'b1;
        default: r_busy_cnt <= r_busy_cnt;
      endcase
    end
  end

  assign busy_cnt = r_busy_cnt;

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] w_raddr;
    assign w_raddr = raddr[g*AW +: AW];

    regfile_rdport #(
      .XLEN (XLEN),
      .AW   (AW),
      .TAGW (TAGW)
    ) u_rdport (
      .i_rst_n   (rst),
      .i_re      (re[g]),
      .i_raddr   (w_raddr),
      .i_we      (we),
      .i_waddr   (waddr),
      .i_wdata   (wdata),
      .i_release (w_release),
      .i_st_data (r_regs[w_raddr]),
      .i_st_busy (r_busy[w_raddr]),
      .i_st_tag  (r_tag[w_raddr]),
      .o_rdata   (rdata[g*XLEN +: XLEN]),
      .o_rbusy   (rbusy[g]),
      .o_rtag    (rtag[g*TAGW +: TAGW])
    );
  end

endmodule

// File: tb/tb_regfile_scb.sv
// Directed bench for regfile_scb: reset, bypass, tag-matched release,
// alloc/commit collision, flush, x0 handling, port disable and async reset.
module tb_regfile_scb;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int NREAD = 2;
  localparam int TAGW  = 4;
  localparam int AW    = 5;

  logic                  clk;
  logic                  rst;
  logic                  we;
  logic [AW-1:0]         waddr;
  logic [XLEN-1:0]       wdata;
  logic [TAGW-1:0]       wtag;
  logic                  alloc;
  logic [AW-1:0]         alloc_addr;
  logic [TAGW-1:0]       alloc_tag;
  logic                  flush;
  logic [NREAD-1:0]      re;
  logic [NREAD*AW-1:0]   raddr;
  logic [NREAD*XLEN-1:0] rdata;
  logic [NREAD-1:0]      rbusy;
  logic [NREAD*TAGW-1:0] rtag;
  logic [AW:0]           busy_cnt;

  int checks = 0;
  int errors = 0;

  regfile_scb #(
    .XLEN  (XLEN),
    .NREG  (NREG),
    .NREAD (NREAD),
    .TAGW  (TAGW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .wtag       (wtag),
    .alloc      (alloc),
    .alloc_addr (alloc_addr),
    .alloc_tag  (alloc_tag),
    .flush      (flush),
    .re         (re),
    .raddr      (raddr),
    .rdata      (rdata),
    .rbusy      (rbusy),
    .rtag       (rtag),
    .busy_cnt   (busy_cnt)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
    #1;
  endtask

  task automatic idle();
    we    = 1'b0;
    alloc = 1'b0;
    flush = 1'b0;
  endtask

  function automatic logic [XLEN-1:0] rd(input int p);
    return rdata[p*XLEN +: XLEN];
  endfunction

  function automatic logic [TAGW-1:0] tg(input int p);
    return rtag[p*TAGW +: TAGW];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; idle();
    waddr = '0; wdata = '0; wtag = '0;
    alloc_addr = '0; alloc_tag = '0;
    re = 2'b11; raddr = {5'd5, 5'd5};
    #1;
    chk("rst_rdata0", rd(0), 0);
    chk("rst_rdata1", rd(1), 0);
    chk("rst_rbusy",  rbusy, 0);
    chk("rst_cnt",    busy_cnt, 0);
    tick();

    // Commit x5 after reset release
    rst = 1'b1;
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; wtag = 4'd0;
    tick(); idle();
    set_rd(5'd5, 5'd0);
    chk("x5_stored", rd(0), 32'hDEADBEEF);

    // Preload x8, then bypass x7 while port 1 reads x8
    we = 1'b1; waddr = 5'd8; wdata = 32'h8888;
    tick();
    waddr = 5'd7; wdata = 32'h1234;
    set_rd(5'd7, 5'd8);
    chk("bypass_rd0", rd(0), 32'h1234);
    chk("bypass_rd1", rd(1), 32'h8888);
    tick(); idle();

    // Tag match: alloc x3 tag 2, commit tag 1 does not release
    alloc = 1'b1; alloc_addr = 5'd3; alloc_tag = 4'd2;
    tick(); idle();
    we = 1'b1; waddr = 5'd3; wdata = 32'h33; wtag = 4'd1;
    tick(); idle();
    set_rd(5'd3, 5'd0);
    chk("tagmiss_data", rd(0), 32'h33);
    chk("tagmiss_busy", rbusy[0], 1'b1);
    chk("tagmiss_tag",  tg(0), 4'd2);
    chk("tagmiss_cnt",  busy_cnt, 1);
    we = 1'b1; waddr = 5'd3; wdata = 32'h44; wtag = 4'd2;
    #1;
    chk("release_bypass_busy", rbusy[0], 1'b0);
    chk("release_bypass_data", rd(0), 32'h44);
    tick(); idle(); #1;
    chk("release_cnt",  busy_cnt, 0);
    chk("release_busy", rbusy[0], 1'b0);

    // Alloc and commit to same register on the same edge
    alloc = 1'b1; alloc_addr = 5'd4; alloc_tag = 4'd3;
    tick(); idle();
    chk("x4_alloc_cnt", busy_cnt, 1);
    alloc = 1'b1; alloc_addr = 5'd4; alloc_tag = 4'd5;
    we = 1'b1; waddr = 5'd4; wdata = 32'h4444; wtag = 4'd3;
    set_rd(5'd4, 5'd0);
    chk("collide_bypass_busy", rbusy[0], 1'b1);
    tick(); idle(); #1;
    chk("collide_busy", rbusy[0], 1'b1);
    chk("collide_tag",  tg(0), 4'd5);
    chk("collide_data", rd(0), 32'h4444);
    chk("collide_cnt",  busy_cnt, 1);

    // Flush with a dropped same-cycle alloc
    alloc = 1'b1; alloc_tag = 4'd1;
    alloc_addr = 5'd1; tick();
    alloc_addr = 5'd2; tick();
    alloc_addr = 5'd9; tick();
    alloc = 1'b0; #1;
    chk("preflush_cnt", busy_cnt, 4);
    flush = 1'b1; alloc = 1'b1; alloc_addr = 5'd10; alloc_tag = 4'd6;
    tick(); idle();
    set_rd(5'd10, 5'd1);
    chk("flush_cnt",    busy_cnt, 0);
    chk("flush_x10",    rbusy[0], 1'b0);
    chk("flush_x1",     rbusy[1], 1'b0);
    set_rd(5'd9, 5'd4);
    chk("flush_x9_x4",  rbusy, 2'b00);

    // x0 is never written nor busy
    alloc = 1'b1; alloc_addr = 5'd0; alloc_tag = 4'd7;
    tick(); idle();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF;
    set_rd(5'd0, 5'd0);
    chk("x0_bypass_data", rd(0), 0);
    chk("x0_bypass_busy", rbusy[0], 1'b0);
    tick(); idle(); #1;
    chk("x0_cnt",  busy_cnt, 0);
    chk("x0_data", rd(1), 0);

    // Port disable: port 1 reads zeros even for a busy, written register
    we = 1'b1; waddr = 5'd6; wdata = 32'h66;
    tick(); idle();
    alloc = 1'b1; alloc_addr = 5'd6; alloc_tag = 4'd9;
    tick(); idle();
    re = 2'b01;
    set_rd(5'd6, 5'd6);
    chk("dis_rd1",   rd(1), 0);
    chk("dis_busy1", rbusy[1], 1'b0);
    chk("dis_tag1",  tg(1), 0);
    chk("en_rd0",    rd(0), 32'h66);
    chk("en_busy0",  rbusy[0], 1'b1);
    chk("en_tag0",   tg(0), 4'd9);
    chk("pre_arst_cnt", busy_cnt, 1);

    // Asynchronous reset away from any clock edge
    re = 2'b11;
    #1;
    rst = 1'b0;
    #1;
    chk("arst_cnt",  busy_cnt, 0);
    chk("arst_rd0",  rd(0), 0);
    chk("arst_busy", rbusy, 2'b00);
    tick();
    rst = 1'b1;
    #1;
    chk("post_arst_x6",   rd(0), 0);
    chk("post_arst_busy", rbusy, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
